// File: rtl/adc_pkg.sv
// Shared definitions for the 14-bit, 7-lane DDR ADC receive path.
// Holds the word/lane geometry, the alignment FSM states and the output-coding decode.
package adc_pkg;

    localparam int ADC_DW    = 14;
    localparam int ADC_LANES = 7;

    typedef enum logic [1:0] {
        SEARCH,
        SETTLE,
        LOCKED,
        FAIL
    } deser_state_t;

    // The ADC keeps the MSB and inverts bits 12:0 on the wire.
    function automatic logic [ADC_DW-1:0] adc_decode(input logic [ADC_DW-1:0] raw);
        return {raw[ADC_DW-1], ~raw[ADC_DW-2:0]};
    endfunction

endpackage

// File: rtl/adc_ddr_assemble.sv
// Input registers and half-cycle slip mux: rebuilds the raw 14-bit word from the lane bits.
// A slipped word takes its even bits from the previous cycle's falling-edge sample.
module adc_ddr_assemble
    import adc_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [ADC_LANES-1:0] rise,
    input  logic [ADC_LANES-1:0] fall,
    input  logic                 slip,
    output logic [ADC_DW-1:0]    raw
);

    logic [ADC_LANES-1:0] rise_q;
    logic [ADC_LANES-1:0] fall_q;
    logic [ADC_LANES-1:0] fall_qq;
    logic [ADC_DW-1:0]    raw_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rise_q  <= '0;
            fall_q  <= '0;
            fall_qq <= '0;
        end else begin
            rise_q  <= rise;
            fall_q  <= fall;
            fall_qq <= fall_q;
        end
    end

    always_comb begin
        raw_d = '0;
        for (int k = 0; k < ADC_LANES; k++) begin
            if (slip) begin
                raw_d[2*k]   = fall_qq[k];
                raw_d[2*k+1] = rise_q[k];
            end else begin
                raw_d[2*k]   = rise_q[k];
                raw_d[2*k+1] = fall_q[k];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            raw <= '0;
        end else begin
            raw <= raw_d;
        end
    end

endmodule

// File: rtl/adc_ddr_deser.sv
// Per-channel DDR ADC deserializer: word assembly, training-based half-cycle alignment,
// output decode with sign extension, lock/fail tracking and a saturating lock-loss counter.
module adc_ddr_deser
    import adc_pkg::*;
#(
    parameter int                OUT_DW    = 16,
    parameter logic [ADC_DW-1:0] TRAIN_PAT = 14'h2A5C,
    parameter int                MATCH_N   = 8,
    parameter int                TMO       = 1024
) (
    input  logic                 adc_clk_i,
    input  logic                 adc_rstn_i,
    input  logic [ADC_LANES-1:0] rise_i,
    input  logic [ADC_LANES-1:0] fall_i,
    input  logic                 train_i,
    output logic [OUT_DW-1:0]    dat_o,
    output logic                 dat_val_o,
    output logic                 lock_o,
    output logic                 slip_o,
    output logic                 fail_o,
    output logic [15:0]          err_cnt_o
);

    localparam int MCNT_W = $clog2(MATCH_N + 1);
    localparam int TCNT_W = $clog2(TMO + 1);
    localparam logic [MCNT_W-1:0] MCNT_LAST = MCNT_W'(MATCH_N - 1);
    localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TMO - 1);

    deser_state_t       state, state_d;
    logic [MCNT_W-1:0]  mcnt, mcnt_d;
    logic [TCNT_W-1:0]  tcnt, tcnt_d;
    logic               scnt, scnt_d;
    logic               slip_d, lock_d, fail_d;
    logic [15:0]        err_d;
    logic               train_prev;
    logic               train_q1, train_q2;
    logic [ADC_DW-1:0]  raw;
    logic [ADC_DW-1:0]  dec;
    logic               match;

    adc_ddr_assemble u_assemble (
        .clk   (adc_clk_i),
        .rst_n (adc_rstn_i),
        .rise  (rise_i),
        .fall  (fall_i),
        .slip  (slip_o),
        .raw   (raw)
    );

    assign match = (raw == TRAIN_PAT);
    assign dec   = adc_decode(raw);

    always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
        if (!adc_rstn_i) begin
            state      <= SEARCH;
            mcnt       <= '0;
            tcnt       <= '0;
            scnt       <= 1'b0;
            slip_o     <= 1'b0;
            lock_o     <= 1'b0;
            fail_o     <= 1'b0;
            err_cnt_o  <= '0;
            train_prev <= 1'b0;
        end else begin
            state      <= state_d;
            mcnt       <= mcnt_d;
            tcnt       <= tcnt_d;
            scnt       <= scnt_d;
            slip_o     <= slip_d;
            lock_o     <= lock_d;
            fail_o     <= fail_d;
            err_cnt_o  <= err_d;
            train_prev <= train_i;
        end
    end

    always_comb begin
        state_d = state;
        mcnt_d  = mcnt;
        tcnt_d  = tcnt;
        scnt_d  = scnt;
        slip_d  = slip_o;
        lock_d  = lock_o;
        fail_d  = fail_o;
        err_d   = err_cnt_o;
        unique case (state)
            SEARCH: begin
                if (train_i) begin
                    tcnt_d = tcnt + TCNT_W'(1);
                    if (tcnt == TCNT_LAST) begin
                        state_d = FAIL;
                        fail_d  = 1'b1;
                        mcnt_d  = '0;
                    end else if (match) begin
                        if (mcnt == MCNT_LAST) begin
                            state_d = LOCKED;
                            lock_d  = 1'b1;
                            mcnt_d  = '0;
                        end else begin
                            mcnt_d = mcnt + MCNT_W'(1);
                        end
                    end else begin
                        mcnt_d  = '0;
                        slip_d  = ~slip_o;
                        scnt_d  = 1'b0;
                        state_d = SETTLE;
                    end
                end
            end
            SETTLE: begin
                // Two cycles let the new slip setting propagate through the raw register.
                if (train_i) begin
                    tcnt_d = tcnt + TCNT_W'(1);
                    if (tcnt == TCNT_LAST) begin
                        state_d = FAIL;
                        fail_d  = 1'b1;
                        mcnt_d  = '0;
                    end else if (scnt) begin
                        state_d = SEARCH;
                    end else begin
                        scnt_d = 1'b1;
                    end
                end
            end
            LOCKED: begin
                if (train_i && !match) begin
                    lock_d  = 1'b0;
                    mcnt_d  = '0;
                    tcnt_d  = '0;
                    state_d = SEARCH;
                    if (err_cnt_o != 16'hFFFF) begin
                        err_d = err_cnt_o + 16'd1;
                    end
                end
            end
            FAIL: begin
                if (train_i && !train_prev) begin
                    state_d = SEARCH;
                    tcnt_d  = '0;
                    mcnt_d  = '0;
                    slip_d  = 1'b0;
                    fail_d  = 1'b0;
                end
            end
            default: begin
                state_d = SEARCH;
            end
        endcase
    end

    // train_i is delayed alongside the data so valid rises with the first post-training word.
    always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
        if (!adc_rstn_i) begin
            train_q1  <= 1'b0;
            train_q2  <= 1'b0;
            dat_o     <= '0;
            dat_val_o <= 1'b0;
        end else begin
            train_q1  <= train_i;
            train_q2  <= train_q1;
            dat_o     <= OUT_DW'($signed(dec));
            dat_val_o <= lock_o & ~train_q2;
        end
    end

endmodule

// File: tb/tb_adc_ddr_deser.sv
// Directed-plus-random bench for adc_ddr_deser: decode, normal and skewed training,
// lock loss, mid-stream reset and training timeout, checked against a word-level model.
module tb_adc_ddr_deser;
    import adc_pkg::*;

    localparam int          OUT_DW  = 16;
    localparam logic [13:0] PAT     = 14'h2A5C;
    localparam int          MATCH_N = 8;
    localparam int          TMO     = 1024;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [6:0]  rise = '0;
    logic [6:0]  fall = '0;
    logic        train = 1'b0;
    logic [15:0] dat;
    logic        dat_val, lock, slip, fail;
    logic [15:0] err_cnt;

    int total = 0;
    int bad   = 0;

    logic [13:0] hist[$];
    logic        thist[$];
    logic [13:0] prev_w = '0;

    always #5 clk = ~clk;

    adc_ddr_deser #(
        .OUT_DW    (OUT_DW),
        .TRAIN_PAT (PAT),
        .MATCH_N   (MATCH_N),
        .TMO       (TMO)
    ) dut (
        .adc_clk_i  (clk),
        .adc_rstn_i (rstn),
        .rise_i     (rise),
        .fall_i     (fall),
        .train_i    (train),
        .dat_o      (dat),
        .dat_val_o  (dat_val),
        .lock_o     (lock),
        .slip_o     (slip),
        .fail_o     (fail),
        .err_cnt_o  (err_cnt)
    );

    // Wire value is MSB-kept, low 13 bits inverted; the sample is a signed 14-bit number.
    function automatic logic [15:0] model_decode(input logic [13:0] w);
        int v;
        v = int'(w ^ 14'h1FFF);
        if (v >= 8192) v = v - 16384;
        return 16'(v);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick_n(input logic [13:0] w, input logic t);
        logic [6:0] r, f;
        for (int k = 0; k < 7; k++) begin
            r[k] = w[2*k];
            f[k] = w[2*k+1];
        end
        rise = r; fall = f; train = t;
        @(posedge clk); #1;
        hist.push_back(w); thist.push_back(t); prev_w = w;
    endtask

    task automatic tick_s(input logic [13:0] w, input logic t);
        logic [6:0] r, f;
        for (int k = 0; k < 7; k++) begin
            r[k] = prev_w[2*k+1];
            f[k] = w[2*k];
        end
        rise = r; fall = f; train = t;
        @(posedge clk); #1;
        hist.push_back(w); thist.push_back(t); prev_w = w;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_dat"},  32'(dat),     32'd0);
        check({tag, "_val"},  32'(dat_val), 32'd0);
        check({tag, "_lock"}, 32'(lock),    32'd0);
        check({tag, "_slip"}, 32'(slip),    32'd0);
        check({tag, "_fail"}, 32'(fail),    32'd0);
        check({tag, "_err"},  32'(err_cnt), 32'd0);
    endtask

    task automatic do_reset();
        rstn = 1'b0; rise = '0; fall = '0; train = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        hist.delete(); thist.delete(); prev_w = '0;
    endtask

    initial begin
        logic [13:0] lit_w  [4];
        logic [15:0] lit_d  [4];
        logic [13:0] w, bad_w;
        int sz;

        lit_w = '{14'h0000, 14'h1FFF, 14'h2000, 14'h3FFF};
        lit_d = '{16'h1FFF, 16'h0000, 16'hFFFF, 16'hE000};

        // Reset state
        rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        do_reset();

        // Decode of boundary words, output three clocks after capture
        for (int i = 0; i < 6; i++) begin
            w = (i < 4) ? lit_w[i] : 14'($urandom);
            tick_n(w, 1'b0);
            if (i >= 2) begin
                check("decode_lit", 32'(dat), 32'(lit_d[i-2]));
                check("decode_val", 32'(dat_val), 32'd0);
            end
        end

        // Training, normal alignment
        repeat (3) tick_n(PAT, 1'b0);
        for (int i = 1; i <= MATCH_N; i++) begin
            tick_n(PAT, 1'b1);
            check("train_lock", 32'(lock), 32'(i == MATCH_N));
            check("train_slip", 32'(slip), 32'd0);
        end

        // Locked data, random words
        for (int i = 0; i < 20; i++) begin
            tick_n(14'($urandom), 1'b0);
            sz = hist.size();
            check("data_dat", 32'(dat), 32'(model_decode(hist[sz-3])));
            check("data_val", 32'(dat_val), 32'(!thist[sz-3]));
        end

        // Lock loss on one corrupted training word
        repeat (2) tick_n(PAT, 1'b0);
        repeat (3) begin
            tick_n(PAT, 1'b1);
            check("ll_hold", 32'(lock), 32'd1);
        end
        bad_w = 14'($urandom);
        if (bad_w == PAT) bad_w = bad_w ^ 14'h0001;
        tick_n(bad_w, 1'b1);
        check("ll_pre0", 32'(lock), 32'd1);
        tick_n(PAT, 1'b1);
        check("ll_pre1", 32'(lock), 32'd1);
        tick_n(PAT, 1'b1);
        check("ll_drop", 32'(lock), 32'd0);
        check("ll_err", 32'(err_cnt), 32'd1);
        for (int i = 1; i <= MATCH_N; i++) begin
            tick_n(PAT, 1'b1);
            check("ll_relock", 32'(lock), 32'(i == MATCH_N));
            check("ll_slip", 32'(slip), 32'd0);
        end
        check("ll_err_hold", 32'(err_cnt), 32'd1);

        // Reset mid-stream, asserted between clock edges
        for (int i = 0; i < 5; i++) tick_n(14'($urandom), 1'b0);
        check("pre_rst_val", 32'(dat_val), 32'd1);
        #2;
        rstn = 1'b0;
        #1;
        check_all_zero("midrst");
        @(posedge clk); #1;
        rstn = 1'b1;
        hist.delete(); thist.delete(); prev_w = '0;
        for (int i = 0; i < 6; i++) begin
            tick_n(14'($urandom), 1'b0);
            check("post_rst_val", 32'(dat_val), 32'd0);
            check("post_rst_lock", 32'(lock), 32'd0);
        end

        // Training with half-cycle skew: one mismatch, slip, two settle cycles, then lock
        repeat (3) tick_s(PAT, 1'b0);
        for (int i = 1; i <= MATCH_N + 3; i++) begin
            tick_s(PAT, 1'b1);
            check("skew_lock", 32'(lock), 32'(i == MATCH_N + 3));
            check("skew_slip", 32'(slip), 32'd1);
        end
        for (int i = 0; i < 20; i++) begin
            tick_s(14'($urandom), 1'b0);
            sz = hist.size();
            check("skew_dat", 32'(dat), 32'(model_decode(hist[sz-4])));
            if (i >= 3) check("skew_val", 32'(dat_val), 32'd1);
        end
        check("skew_err", 32'(err_cnt), 32'd0);

        // Training timeout on a constant wrong word
        do_reset();
        for (int i = 1; i <= TMO; i++) begin
            tick_n(14'h0000, 1'b1);
            if (i >= TMO - 1) check("tmo_fail", 32'(fail), 32'(i == TMO));
        end
        check("tmo_lock", 32'(lock), 32'd0);
        repeat (2) begin
            tick_n(14'h0000, 1'b0);
            check("tmo_hold", 32'(fail), 32'd1);
        end
        tick_n(14'h0000, 1'b1);
        check("tmo_exit_fail", 32'(fail), 32'd0);
        check("tmo_exit_slip", 32'(slip), 32'd0);
        check("tmo_exit_lock", 32'(lock), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
